data_memory_ctrl: RTL
=====================

// Module: data_memory_ctrl
// PURPOSE
// - Byte-addressable, big-endian data memory for the MIPS datapath; successor to the fixed 64-byte word-read memory.
// - Serves lb/lbu/lh/lhu/lw/sb/sh/sw through a valid/ready request port with a registered, 1-cycle response.
// - Checks alignment and range on every request. Optionally zeroes the array with a post-reset sweep FSM, one word per cycle.
// PARAMETERS
// - MEM_BYTES       64  array size in bytes; power of two, >= 8
// - CLEAR_ON_RESET  1   1: run CLEAR sweep after reset; 0: go straight to IDLE, contents undefined
// PORTS
// - clk         in   1   clock, rising edge
// - rst         in   1   reset, synchronous, active-high
// - req_valid   in   1   request present
// - req_ready   out  1   request may be accepted this cycle
// - req_write   in   1   1 store, 0 load
// - req_size    in   2   00 byte, 01 half, 10 word, 11 illegal
// - req_signed  in   1   loads only: 1 sign-extend, 0 zero-extend
// - req_addr    in   32  byte address
// - req_wdata   in   32  store data, right-justified (byte in [7:0], half in [15:0])
// - resp_valid  out  1   one-cycle pulse, exactly one per accepted request
// - resp_rdata  out  32  load result; 0 for stores and errors
// - resp_err    out  1   request rejected (misaligned / out of range / illegal size)
// - clearing    out  1   CLEAR sweep in progress
// BEHAVIOUR
// - Reset: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, clear_ptr=0.
//   - State becomes CLEAR if CLEAR_ON_RESET, else IDLE.
//   - rst asserted mid-sweep restarts the sweep at word 0.
//   - rst with a response pending drops that response (resp_valid=0 next cycle).
// - CLEAR: each cycle writes 0 to bytes 4*clear_ptr..+3 and increments clear_ptr.
//   - clearing=1 and req_ready=0 throughout.
//   - After the word at clear_ptr=MEM_BYTES/4-1 is written, go to IDLE. The sweep lasts exactly MEM_BYTES/4 cycles.
// - IDLE: req_ready=1, clearing=0. Accept on req_valid & req_ready.
//   - Back-to-back requests are allowed, one per cycle.
// - Accept cycle (edge T): a legal store updates its bytes at edge T. Load data is sampled from the array at edge T.
//   - resp_valid=1 during T+1 only; resp_rdata and resp_err are valid with it.
//   - A load accepted the cycle after a store to the same address returns the new data.
// - Endianness: byte at addr a is most significant.
//   - Word = {m[a],m[a+1],m[a+2],m[a+3]}; half = {m[a],m[a+1]}.
//   - sb writes wdata[7:0] to m[a]; sh writes wdata[15:8] to m[a] and wdata[7:0] to m[a+1].
// - Load extension: byte/half extended to 32 bits per req_signed. Word loads ignore req_signed.
// - Errors, checked on the full 32-bit req_addr:
//   - half with addr[0]!=0;
//   - word with addr[1:0]!=0;
//   - addr > MEM_BYTES-nbytes (nbytes = 1, 2 or 4);
//   - req_size==11.
//   - On error: no array write, resp_err=1, resp_rdata=0.
// - No request accepted: resp_valid=0; resp_rdata and resp_err hold their previous values.
// - Array has no reset of its own. Contents are zero only via CLEAR; the contents of unaddressed bytes are never altered.
// STRUCTURE
// - Package dmem_pkg:
//   - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL;
//   - state enum {CLEAR, IDLE};
//   - function nbytes(size).
// - Sub-module dmem_align (combinational): takes the 4 raw bytes at a, size and signed; returns the extended rdata. Also produces the byte enables and lane data for stores.
// - Top holds the array, FSM, clear_ptr, error check and response registers.
// TESTING
// - Reset with MEM_BYTES=64: clearing=1 and req_ready=0 for exactly 16 cycles, then ready=1. A lw at any word returns 0.
// - Byte lanes: sw 0x000C=0x8091A2B3, then loads at 0x000C:
//   - lbu -> 0x00000080; lb -> 0xFFFFFF80;
//   - lh 0x000E -> 0xFFFFA2B3; lhu 0x000C -> 0x00008091.
// - Store merge: sb 0x0011=0x5A over word 0x0010=0x11223344, then lw 0x0010 -> 0x115A3344. Back-to-back store->load gives new data next cycle.
// - Errors: each case gives resp_err=1 and rdata=0, and a following lw 0x0000 shows memory unchanged.
//   - lw 0x0002; lh 0x0001; lw 0x003C ok but lw 0x0040 err; sw 0xFFFFFFFC err; size=11.
// - Reset mid-sweep at cycle 7: sweep restarts and lasts 16 more cycles. Reset with a load in flight: no resp_valid pulse.
// - Throughput: 10 consecutive accepted requests give 10 resp_valid pulses, each 1 cycle after its accept.

Source files
------------

// File: rtl/data_memory_ctrl_pkg.sv
// Shared encodings and helpers for the byte-addressable big-endian data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Illegal size reports 4 bytes; it is rejected separately anyway.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: nbytes = 3'd1;
            SZ_HALF: nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response port of the data memory: valid/ready request, 1-cycle registered response.
interface data_memory_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_memory_ctrl_align.sv
// Big-endian lane steering: raw[31:24] is the byte at the request address.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wlanes
);

    always_comb begin
        rdata  = '0;
        be     = '0;
        wlanes = '0;
        case (size)
            SZ_BYTE: begin
                rdata  = {{24{sgn & raw[31]}}, raw[31:24]};
                be     = 4'b1000;
                wlanes = {wdata[7:0], 24'd0};
            end
            SZ_HALF: begin
                rdata  = {{16{sgn & raw[31]}}, raw[31:16]};
                be     = 4'b1100;
                wlanes = {wdata[15:0], 16'd0};
            end
            SZ_WORD: begin
                rdata  = raw;
                be     = 4'b1111;
                wlanes = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressable big-endian data memory with alignment/range checking and optional post-reset clear sweep.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES      = 64,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    data_memory_ctrl_if.slave bus,
    output logic              clearing
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int PW = AW - 2;
    localparam logic [PW-1:0] PTR_LAST = PW'(MEM_BYTES / 4 - 1);

    logic [7:0]    mem [MEM_BYTES];
    state_t        state, state_nxt;
    logic [PW-1:0] clear_ptr, clear_ptr_nxt;
    logic          idle_ready, clr_we, acc, err, st_we;
    logic [AW-1:0] addr;
    logic [31:0]   lim, raw, ld_data, wlanes;
    logic [3:0]    be;
    logic          vld_p1, err_p1;
    logic [31:0]   rdata_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clear_ptr <= '0;
        end else begin
            state     <= state_nxt;
            clear_ptr <= clear_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clear_ptr_nxt = clear_ptr;
        clearing      = 1'b0;
        idle_ready    = 1'b0;
        case (state)
            CLEAR: begin
                clearing      = 1'b1;
                clear_ptr_nxt = clear_ptr + 1'b1;
                if (clear_ptr == PTR_LAST) state_nxt = IDLE;
            end
            IDLE:    idle_ready = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // Nothing is accepted or written while rst is held, so an in-flight request is dropped.
    assign bus.req_ready = idle_ready & ~rst;
    assign clr_we        = clearing & ~rst;
    assign acc           = bus.req_valid & bus.req_ready;

    assign addr = bus.req_addr[AW-1:0];
    assign lim  = 32'(MEM_BYTES) - 32'(nbytes(bus.req_size));
    assign err  = (bus.req_size == SZ_ILL)
                | ((bus.req_size == SZ_HALF) & bus.req_addr[0])
                | ((bus.req_size == SZ_WORD) & (|bus.req_addr[1:0]))
                | (bus.req_addr > lim);
    assign st_we = acc & bus.req_write & ~err;

    always_comb begin
        raw = '0;
        for (int i = 0; i < 4; i++) raw[31-8*i -: 8] = mem[addr + AW'(i)];
    end

    dmem_align u_align (
        .raw    (raw),
        .size   (bus.req_size),
        .sgn    (bus.req_signed),
        .wdata  (bus.req_wdata),
        .rdata  (ld_data),
        .be     (be),
        .wlanes (wlanes)
    );

    always_ff @(posedge clk) begin
        if (clr_we) begin
            for (int i = 0; i < 4; i++) mem[{clear_ptr, 2'(i)}] <= '0;
        end else if (st_we) begin
            for (int i = 0; i < 4; i++)
                if (be[3-i]) mem[addr + AW'(i)] <= wlanes[31-8*i -: 8];
        end
    end

    // Response stage: registered one cycle after the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= acc;
            if (acc) begin
                err_p1   <= err;
                rdata_p1 <= (err | bus.req_write) ? 32'd0 : ld_data;
            end
        end
    end

    assign bus.resp_valid = vld_p1;
    assign bus.resp_rdata = rdata_p1;
    assign bus.resp_err   = err_p1;

endmodule
